// File: rtl/hilo_pkg.sv
// Shared encodings and helpers for the HI/LO scheduler and its divider.
package hilo_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DLEN = 64;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MADD  = 4'd3,
    OP_MADDU = 4'd4,
    OP_MSUB  = 4'd5,
    OP_MSUBU = 4'd6,
    OP_DIV   = 4'd7,
    OP_DIVU  = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10,
    OP_MFHI  = 4'd11,
    OP_MFLO  = 4'd12
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DIV_FIX = 2'd3
  } hilo_state_e;

  function automatic logic is_mul_op(input hilo_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  // Full 64-bit product; signedness follows the opcode.
  function automatic logic [DLEN-1:0] mul_product(input hilo_op_e op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic signed [DLEN-1:0] sa;
    logic signed [DLEN-1:0] sb;
    sa = DLEN'($signed(a));
    sb = DLEN'($signed(b));
    if (op inside {OP_MULT, OP_MADD, OP_MSUB}) begin
      return DLEN'(sa * sb);
    end
    return DLEN'(a) * DLEN'(b);
  endfunction

endpackage

// File: rtl/hilo_divider.sv
// Unsigned restoring divider; done pulses DIV_CYCLES cycles after start.
module hilo_divider
  import hilo_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int unsigned BITS_PER_CYC = (XLEN + DIV_CYCLES - 1) / DIV_CYCLES;
  localparam int unsigned CW           = $clog2(XLEN + 1);

  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   bits_q, bits_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            done_q, done_d;
  logic [XLEN:0]   sh;

  // First iteration happens in the start cycle so the result lands on time.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    bits_d = bits_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    sh     = '0;
    if (start || run_q) begin
      if (start) begin
        rem_d  = '0;
        quo_d  = dividend;
        dvs_d  = divisor;
        bits_d = CW'(XLEN);
        cnt_d  = CW'(DIV_CYCLES);
      end
      for (int unsigned i = 0; i < BITS_PER_CYC; i++) begin
        if (bits_d != '0) begin
          sh = {rem_d[XLEN-1:0], quo_d[XLEN-1]};
          if (sh >= {1'b0, dvs_d}) begin
            rem_d = sh - {1'b0, dvs_d};
            quo_d = {quo_d[XLEN-2:0], 1'b1};
          end else begin
            rem_d = sh;
            quo_d = {quo_d[XLEN-2:0], 1'b0};
          end
          bits_d = bits_d - CW'(1);
        end
      end
      cnt_d  = cnt_d - CW'(1);
      run_d  = (cnt_d != '0);
      done_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      bits_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[XLEN-1:0];
  assign done      = done_q;

endmodule

// File: rtl/hilo_scheduler.sv
// HI/LO register pair owner: sequences multiply, divide and HI/LO moves from EX.
module hilo_scheduler
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [3:0]      op_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            ex_stall,
  input  logic            ex_flush,
  output logic [XLEN-1:0] rd_data,
  output logic            hilo_stall,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  hilo_state_e     state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic            sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
  logic            div_start_q, div_start_d;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            div_done;

  hilo_op_e        op;
  logic            op_req_c, accept_c, mul_go_c;
  logic [DLEN-1:0] mul_p_q [MUL_LAT];
  logic [MUL_LAT-1:0] mul_vld_q;
  hilo_op_e        mul_op_q;
  logic [DLEN-1:0] acc_c;

  // Stall and busy are forced low while reset is held.
  assign op         = hilo_op_e'(op_code);
  assign op_req_c   = op_valid && (op != OP_NONE);
  assign busy       = reset && (state_q != ST_IDLE);
  assign hilo_stall = reset && op_req_c && (state_q != ST_IDLE);
  assign accept_c   = reset && op_req_c && !ex_stall && !ex_flush && !hilo_stall;
  assign mul_go_c   = accept_c && is_mul_op(op);
  assign rd_data    = !accept_c         ? '0   :
                      (op == OP_MFHI)   ? hi_q :
                      (op == OP_MFLO)   ? lo_q : '0;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign acc_c      = {hi_q, lo_q};

  always_ff @(posedge clock) begin
    if (!reset) begin
      mul_vld_q <= '0;
    end else begin
      mul_vld_q[0] <= mul_go_c;
      for (int unsigned i = 1; i < MUL_LAT; i++) mul_vld_q[i] <= mul_vld_q[i-1];
    end
  end

  // Product pipeline carries data only; validity lives in mul_vld_q.
  always_ff @(posedge clock) begin
    mul_p_q[0] <= mul_product(op, op_a, op_b);
    for (int unsigned i = 1; i < MUL_LAT; i++) mul_p_q[i] <= mul_p_q[i-1];
    if (mul_go_c) mul_op_q <= op;
  end

  hilo_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start_q),
    .dividend  (div_a_q),
    .divisor   (div_b_q),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    sgn_a_d     = sgn_a_q;
    sgn_b_d     = sgn_b_q;
    div_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: state_d = ST_MUL_RUN;
            OP_DIV, OP_DIVU: begin
              if (op_b == '0) begin
                hi_d = op_a;
                lo_d = '1;
              end else begin
                sgn_a_d     = (op == OP_DIV) && op_a[XLEN-1];
                sgn_b_d     = (op == OP_DIV) && op_b[XLEN-1];
                div_a_d     = sgn_a_d ? -op_a : op_a;
                div_b_d     = sgn_b_d ? -op_b : op_b;
                div_start_d = 1'b1;
                state_d     = ST_DIV_RUN;
              end
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_b;
            default: ;
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (mul_vld_q[MUL_LAT-1]) begin
          case (mul_op_q)
            OP_MADD, OP_MADDU: {hi_d, lo_d} = acc_c + mul_p_q[MUL_LAT-1];
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc_c - mul_p_q[MUL_LAT-1];
            default:           {hi_d, lo_d} = mul_p_q[MUL_LAT-1];
          endcase
          state_d = ST_IDLE;
        end
      end
      ST_DIV_RUN: if (div_done) state_d = ST_DIV_FIX;
      ST_DIV_FIX: begin
        lo_d    = (sgn_a_q ^ sgn_b_q) ? -div_quo : div_quo;
        hi_d    = sgn_a_q ? -div_rem : div_rem;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      sgn_a_q     <= 1'b0;
      sgn_b_q     <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      sgn_a_q     <= sgn_a_d;
      sgn_b_q     <= sgn_b_d;
      div_start_q <= div_start_d;
    end
  end

endmodule

// File: tb/tb_hilo_scheduler.sv
// Scoreboard bench for hilo_scheduler: MFHI/MFLO reads checked against queued expectations.
module tb_hilo_scheduler;
  import hilo_pkg::*;

  localparam int unsigned MUL_LAT    = 2;
  localparam int unsigned DIV_CYCLES = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op_code = 4'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ex_stall = 1'b0;
  logic        ex_flush = 1'b0;
  logic [31:0] rd_data;
  logic        hilo_stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clock = ~clock;

  hilo_scheduler #(.MUL_LAT(MUL_LAT), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clock      (clock),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .ex_stall   (ex_stall),
    .ex_flush   (ex_flush),
    .rd_data    (rd_data),
    .hilo_stall (hilo_stall),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted MFHI/MFLO pops one expectation; otherwise rd_data must be 0.
  always @(negedge clock) begin
    if (reset && op_valid && !ex_stall && !ex_flush && !hilo_stall &&
        (op_code == OP_MFHI || op_code == OP_MFLO)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected read: rd_data=%h with empty scoreboard", rd_data);
      end else begin
        check(name_q.pop_front(), rd_data, exp_q.pop_front());
      end
    end else if (op_valid) begin
      check("rd_data not accepted", rd_data, 32'h0);
    end
  end

  // Presents an op from posedge+1 until accepted; returns number of stalled cycles.
  task automatic issue(input hilo_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    bit acc = 1'b0;
    stalls   = 0;
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    while (!acc && stalls < 200) begin
      @(negedge clock);
      if (hilo_stall) stalls++;
      else acc = 1'b1;
      @(posedge clock); #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue timeout: op %0d still stalled after %0d cycles", op, stalls);
    end
    op_valid = 1'b0;
    op_code  = OP_NONE;
  endtask

  task automatic rd(input hilo_op_e op, input string name, input logic [31:0] e,
                    output int stalls);
    exp_q.push_back(e);
    name_q.push_back(name);
    issue(op, 32'h0, 32'h0, stalls);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s;
    bit dirty;

    // Reset with a pending request: nothing may stall or read.
    repeat (2) @(posedge clock);
    #1;
    op_valid = 1'b1;
    op_code  = OP_MFHI;
    @(negedge clock);
    check("reset busy", 32'(busy), 32'h0);
    check("reset hilo_stall", 32'(hilo_stall), 32'h0);
    @(posedge clock); #1;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = OP_NONE;
    @(negedge clock);
    check("post-reset hi", hi, 32'h0);
    check("post-reset lo", lo, 32'h0);
    @(posedge clock); #1;
    rd(OP_MFHI, "reset mfhi", 32'h0, s);
    rd(OP_MFLO, "reset mflo", 32'h0, s);

    // MULT -2 * 3, read back-to-back
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, s);
    rd(OP_MFLO, "mult lo", 32'hFFFF_FFFA, s);
    check("mult stall cycles", 32'(s), 32'(MUL_LAT));
    rd(OP_MFHI, "mult hi", 32'hFFFF_FFFF, s);
    check("no stall when idle", 32'(s), 32'h0);

    // MADDU carry across the 32-bit boundary
    issue(OP_MTHI, 32'h0, 32'h0, s);
    issue(OP_MTLO, 32'h0, 32'hFFFF_FFFF, s);
    issue(OP_MADDU, 32'd1, 32'd1, s);
    rd(OP_MFHI, "maddu hi", 32'h1, s);
    rd(OP_MFLO, "maddu lo", 32'h0, s);

    // MSUB borrow: 5 - 6 = -1
    issue(OP_MTHI, 32'h0, 32'h0, s);
    issue(OP_MTLO, 32'h0, 32'd5, s);
    issue(OP_MSUB, 32'd2, 32'd3, s);
    rd(OP_MFHI, "msub hi", 32'hFFFF_FFFF, s);
    rd(OP_MFLO, "msub lo", 32'hFFFF_FFFF, s);

    // MULTU max * max
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
    rd(OP_MFHI, "multu hi", 32'hFFFF_FFFE, s);
    rd(OP_MFLO, "multu lo", 32'h0000_0001, s);

    // DIV -7 / 2 with MFHI waiting from T+1
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, s);
    rd(OP_MFHI, "div hi", 32'hFFFF_FFFF, s);
    check("div stall cycles", 32'(s), 32'(DIV_CYCLES + 2));
    rd(OP_MFLO, "div lo", 32'hFFFF_FFFD, s);

    // DIVU by zero bypass
    issue(OP_DIVU, 32'd10, 32'd0, s);
    @(negedge clock);
    check("div0 busy", 32'(busy), 32'h0);
    check("div0 hi", hi, 32'd10);
    check("div0 lo", lo, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    rd(OP_MFHI, "div0 mfhi", 32'd10, s);
    check("div0 no stall", 32'(s), 32'h0);

    // Signed overflow corner and an unsigned divide
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
    rd(OP_MFLO, "div ovf lo", 32'h8000_0000, s);
    rd(OP_MFHI, "div ovf hi", 32'h0, s);
    issue(OP_DIVU, 32'd100, 32'd7, s);
    rd(OP_MFLO, "divu lo", 32'd14, s);
    rd(OP_MFHI, "divu hi", 32'd2, s);

    // hilo_stall is not masked by ex_flush
    issue(OP_MULT, 32'd1, 32'd1, s);
    op_valid = 1'b1;
    op_code  = OP_MFHI;
    ex_flush = 1'b1;
    @(negedge clock);
    check("stall under flush", 32'(hilo_stall), 32'h1);
    @(posedge clock); #1;
    ex_flush = 1'b0;
    op_valid = 1'b0;
    op_code  = OP_NONE;
    rd(OP_MFLO, "mult 1x1 lo", 32'h1, s);

    // Flushed / stalled moves have no effect
    issue(OP_MTHI, 32'h1234, 32'h0, s);
    issue(OP_MTLO, 32'h0, 32'h5678, s);
    op_valid = 1'b1;
    op_code  = OP_MTHI;
    op_a     = 32'hDEAD;
    ex_flush = 1'b1;
    @(posedge clock); #1;
    ex_flush = 1'b0;
    ex_stall = 1'b1;
    op_code  = OP_MTLO;
    op_b     = 32'hBEEF;
    @(posedge clock); #1;
    ex_stall = 1'b0;
    op_valid = 1'b0;
    op_code  = OP_NONE;
    rd(OP_MFHI, "flushed mthi", 32'h1234, s);
    rd(OP_MFLO, "stalled mtlo", 32'h5678, s);

    // DIV in flight: flush at T+5 ignored, reset at T+10 aborts
    issue(OP_DIV, 32'd100, 32'd7, s);
    for (int k = 1; k <= 9; k++) begin
      ex_flush = (k == 5);
      @(negedge clock);
      check($sformatf("div busy T+%0d", k), 32'(busy), 32'h1);
      @(posedge clock); #1;
    end
    ex_flush = 1'b0;
    reset    = 1'b0;
    op_valid = 1'b1;
    op_code  = OP_MFHI;
    @(negedge clock);
    check("abort busy in reset", 32'(busy), 32'h0);
    check("abort stall in reset", 32'(hilo_stall), 32'h0);
    @(posedge clock); #1;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = OP_NONE;
    @(negedge clock);
    check("abort busy T+11", 32'(busy), 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    dirty = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (busy || hi != 32'h0 || lo != 32'h0) dirty = 1'b1;
    end
    check("no late divide write", 32'(dirty), 32'h0);
    @(posedge clock); #1;
    rd(OP_MFHI, "abort mfhi", 32'h0, s);
    rd(OP_MFLO, "abort mflo", 32'h0, s);

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_scheduler.md
Name: hilo_scheduler

Overview:
Owns the architectural HI/LO register pair and sequences every HI/LO-class instruction issued from the Execute stage: multiply, multiply-accumulate, divide, move-to and move-from.
- Drives a pipelined multiplier (MUL_LAT stages) and an iterative divider sub-module.
- Performs signed-divide sign correction and divide-by-zero bypass.
- Raises a pipeline stall when a HI/LO access collides with an in-flight operation.
- Sits beside the main ALU in EX; the ALU keeps single-cycle integer ops only.

Parameters:
MUL_LAT, 2, multiplier pipeline depth in cycles (legal 1..4)
DIV_CYCLES, 32, divider iterations from start to done (legal 1..32)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
op_valid  in  1  EX stage presents a HI/LO op this cycle
op_code  in  4  HI/LO opcode (package encoding)
op_a  in  32  rs operand / dividend / mthi source
op_b  in  32  rt operand / divisor / mtlo source
ex_stall  in  1  EX stage stalled by other logic
ex_flush  in  1  EX instruction squashed
rd_data  out  32  HI (MFHI) or LO (MFLO) read value, combinational
hilo_stall  out  1  stall request to pipeline
busy  out  1  an operation is in flight
hi  out  32  current HI (debug/forwarding)
lo  out  32  current LO

Behaviour:
Reset
- On reset==0: HI=LO=0, state IDLE, multiplier valid pipeline cleared, in-flight divide aborted.
- Outputs during reset: busy=0, hilo_stall=0, rd_data=0.

Accept and stall
- Accept = op_valid & op_code!=NONE & ~ex_stall & ~ex_flush & ~hilo_stall.
- hilo_stall = op_valid & op_code!=NONE & busy.
- hilo_stall is not gated by ex_flush or ex_stall.
- A flushed or stalled op has no side effects.
- ex_flush never cancels an op already accepted.

FSM states: IDLE, MUL_RUN, DIV_RUN, DIV_FIX.
- IDLE, MULT/MULTU/MADD*/MSUB*:
  - Operands enter the multiplier at T.
  - HILO is written at the end of cycle T+MUL_LAT.
  - Next state MUL_RUN; busy=1 for cycles T+1..T+MUL_LAT.
  - Accumulate ops use HILO as of the write cycle.
  - 64-bit add/subtract wraps modulo 2^64.
- IDLE, DIV/DIVU with op_b!=0:
  - Latch |a|, |b| (signed) or a, b (unsigned), plus sign flags.
  - At T+1: pulse div_start; state DIV_RUN.
  - DIV_RUN: wait for div_done (asserted DIV_CYCLES cycles after start), then DIV_FIX.
  - DIV_FIX: negate quotient if sign_a^sign_b; give remainder the sign of the dividend; write HI=rem, LO=quot; return to IDLE.
  - Total latency for DIV_CYCLES=32: HILO written at end of T+34; MFHI accepted at T+35 earliest.
- DIV/DIVU with op_b==0:
  - Single-cycle bypass in IDLE.
  - HI=op_a, LO=32'hFFFF_FFFF; no busy.
- MTHI / MTLO (in IDLE):
  - HI=op_a, or LO=op_b, at end of T.
- MFHI / MFLO:
  - rd_data=HI or LO combinationally when accepted; otherwise rd_data=0.
- Signed corner case: 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0; no exception.
- Divider internals are unsigned 32-bit restoring; the 33-bit partial remainder lives in the sub-module.

Decomposition:
- Shared package hilo_pkg:
  - op_code encodings: NONE=0, MULT=1, MULTU=2, MADD=3, MADDU=4, MSUB=5, MSUBU=6, DIV=7, DIVU=8, MTHI=9, MTLO=10, MFHI=11, MFLO=12.
  - FSM state encoding.
- Sub-module hilo_divider:
  - Unsigned iterative divider.
  - Ports: clock, reset, start, dividend, divisor, quotient, remainder, done.
  - done is a single-cycle pulse.
- Multiplier pipeline and sign fix stay inline.

Test Plan:
- Reset, then MFHI and MFLO -> rd_data=0 both; busy=0.
- MULT a=0xFFFF_FFFE(-2), b=3 -> after MUL_LAT cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; MFLO issued at T+1 sees hilo_stall=1 until HILO written.
- MTHI 0, MTLO 0xFFFF_FFFF, then MADDU a=1, b=1 -> HI=1, LO=0 (carry propagates across 32-bit boundary).
- DIV a=-7, b=2 -> LO=0xFFFF_FFFD(-3), HI=0xFFFF_FFFF(-1); MFHI at T+1 stalls exactly until T+35.
- DIVU a=10, b=0 -> same-cycle HI=10, LO=0xFFFF_FFFF; busy never asserts.
- DIV accepted, ex_flush pulsed at T+5, reset==0 at T+10 -> flush ignored (busy stays 1 through T+9); reset aborts: HI=LO=0, busy=0 at T+11, no later HILO write.
